// File: rtl/npu_sram_pkg.sv
// Shared types and helpers for the banked dual-port NPU buffer.
// Widths of sram_req_t follow the default buffer geometry.
package npu_sram_pkg;

   localparam int SRAM_DW  = 32;
   localparam int SRAM_AW  = 12;
   localparam int SRAM_BEW = SRAM_DW / 8;

   typedef struct packed {
      logic                we;
      logic [SRAM_AW-1:0]  addr;
      logic [SRAM_BEW-1:0] be;
      logic [SRAM_DW-1:0]  wdata;
   } sram_req_t;

   localparam logic PRIO_A = 1'b0;
   localparam logic PRIO_B = 1'b1;

   function automatic int bank_idx_w(input int n_banks);
      return $clog2(n_banks);
   endfunction

   function automatic int row_idx_w(input int n_entries, input int n_banks);
      return $clog2(n_entries) - $clog2(n_banks);
   endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port byte-enable SRAM bank with a registered (synchronous) read.
// Read data is only updated by a read, so it holds between accesses.
module sram_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 1024,
   parameter int ROW_W      = 10,
   parameter int BEW        = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [BEW-1:0]        be_i,
   input  logic [ROW_W-1:0]      row_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [ROWS];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (en_i && !we_i) rdata_d = mem_q[row_i];
   end

   always_ff @(posedge clk_i) begin
      rdata_q <= rdata_d;
      if (en_i && we_i) begin
         for (int b = 0; b < BEW; b++) begin
            if (be_i[b]) mem_q[row_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_banked_dp.sv
// Dual-port, word-interleaved multi-bank buffer with round-robin bank arbitration.
// Define SRAM_OUTREG_EN to add an output register stage (read latency 2).
module sram_banked_dp
   import npu_sram_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int N_ENTRIES  = 4096,
   parameter  int N_BANKS    = 4,
   localparam int ADDRW      = $clog2(N_ENTRIES),
   localparam int BEW        = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  a_valid_i,
   output logic                  a_ready_o,
   input  logic                  a_we_i,
   input  logic [ADDRW-1:0]      a_addr_i,
   input  logic [BEW-1:0]        a_be_i,
   input  logic [DATA_WIDTH-1:0] a_wdata_i,
   output logic                  a_rvalid_o,
   output logic [DATA_WIDTH-1:0] a_rdata_o,
   input  logic                  b_valid_i,
   output logic                  b_ready_o,
   input  logic                  b_we_i,
   input  logic [ADDRW-1:0]      b_addr_i,
   input  logic [BEW-1:0]        b_be_i,
   input  logic [DATA_WIDTH-1:0] b_wdata_i,
   output logic                  b_rvalid_o,
   output logic [DATA_WIDTH-1:0] b_rdata_o
);

   localparam int BB   = bank_idx_w(N_BANKS);
   localparam int RB   = row_idx_w(N_ENTRIES, N_BANKS);
   localparam int ROWS = N_ENTRIES / N_BANKS;

   logic [BB-1:0] a_bank, b_bank;
   logic [RB-1:0] a_row, b_row;
   logic          a_oor, b_oor, conflict;
   logic          prio_q, prio_d;

   logic                  bank_en    [N_BANKS];
   logic                  bank_we    [N_BANKS];
   logic [BEW-1:0]        bank_be    [N_BANKS];
   logic [RB-1:0]         bank_row   [N_BANKS];
   logic [DATA_WIDTH-1:0] bank_wdata [N_BANKS];
   logic [DATA_WIDTH-1:0] bank_rdata [N_BANKS];

   // Return-path tracking: read flag, bank select and out-of-range flag per port.
   logic                  a_rd_q, a_rd_d, b_rd_q, b_rd_d;
   logic [BB-1:0]         a_sel_q, a_sel_d, b_sel_q, b_sel_d;
   logic                  a_oor_q, a_oor_d, b_oor_q, b_oor_d;
   logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
   logic [DATA_WIDTH-1:0] a_rdata_c, b_rdata_c;

   assign a_bank = a_addr_i[BB-1:0];
   assign b_bank = b_addr_i[BB-1:0];
   assign a_row  = a_addr_i[ADDRW-1:BB];
   assign b_row  = b_addr_i[ADDRW-1:BB];
   assign a_oor  = 32'(a_addr_i) >= N_ENTRIES;
   assign b_oor  = 32'(b_addr_i) >= N_ENTRIES;

   always_comb begin
      conflict  = a_valid_i && b_valid_i && (a_bank == b_bank);
      a_ready_o = rst_n_i && a_valid_i && (!conflict || prio_q == PRIO_A);
      b_ready_o = rst_n_i && b_valid_i && (!conflict || prio_q == PRIO_B);
      prio_d    = (rst_n_i && conflict) ? ~prio_q : prio_q;
   end

   // Arbitration guarantees at most one accepted port per bank.
   always_comb begin
      for (int i = 0; i < N_BANKS; i++) begin
         bank_en[i]    = 1'b0;
         bank_we[i]    = 1'b0;
         bank_be[i]    = '0;
         bank_row[i]   = '0;
         bank_wdata[i] = '0;
         if (a_ready_o && a_bank == BB'(i)) begin
            bank_en[i]    = !a_oor;
            bank_we[i]    = a_we_i;
            bank_be[i]    = a_be_i;
            bank_row[i]   = a_row;
            bank_wdata[i] = a_wdata_i;
         end else if (b_ready_o && b_bank == BB'(i)) begin
            bank_en[i]    = !b_oor;
            bank_we[i]    = b_we_i;
            bank_be[i]    = b_be_i;
            bank_row[i]   = b_row;
            bank_wdata[i] = b_wdata_i;
         end
      end
   end

   for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
      sram_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ROWS       (ROWS),
         .ROW_W      (RB),
         .BEW        (BEW)
      ) u_bank (
         .clk_i   (clk_i),
         .en_i    (bank_en[g]),
         .we_i    (bank_we[g]),
         .be_i    (bank_be[g]),
         .row_i   (bank_row[g]),
         .wdata_i (bank_wdata[g]),
         .rdata_o (bank_rdata[g])
      );
   end

   always_comb begin
      a_rd_d    = a_ready_o && !a_we_i;
      b_rd_d    = b_ready_o && !b_we_i;
      a_sel_d   = a_ready_o ? a_bank : a_sel_q;
      b_sel_d   = b_ready_o ? b_bank : b_sel_q;
      a_oor_d   = a_ready_o ? a_oor : a_oor_q;
      b_oor_d   = b_ready_o ? b_oor : b_oor_q;
      a_rdata_c = a_hold_q;
      b_rdata_c = b_hold_q;
      if (a_rd_q) a_rdata_c = a_oor_q ? '0 : bank_rdata[a_sel_q];
      if (b_rd_q) b_rdata_c = b_oor_q ? '0 : bank_rdata[b_sel_q];
      a_hold_d  = a_rdata_c;
      b_hold_d  = b_rdata_c;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prio_q   <= PRIO_A;
         a_rd_q   <= 1'b0;
         b_rd_q   <= 1'b0;
         a_sel_q  <= '0;
         b_sel_q  <= '0;
         a_oor_q  <= 1'b0;
         b_oor_q  <= 1'b0;
         a_hold_q <= '0;
         b_hold_q <= '0;
      end else begin
         prio_q   <= prio_d;
         a_rd_q   <= a_rd_d;
         b_rd_q   <= b_rd_d;
         a_sel_q  <= a_sel_d;
         b_sel_q  <= b_sel_d;
         a_oor_q  <= a_oor_d;
         b_oor_q  <= b_oor_d;
         a_hold_q <= a_hold_d;
         b_hold_q <= b_hold_d;
      end
   end

`ifdef SRAM_OUTREG_EN
   logic                  a_rv2_q, a_rv2_d, b_rv2_q, b_rv2_d;
   logic [DATA_WIDTH-1:0] a_rdata2_q, a_rdata2_d, b_rdata2_q, b_rdata2_d;

   always_comb begin
      a_rv2_d    = a_rd_q;
      b_rv2_d    = b_rd_q;
      a_rdata2_d = a_rdata_c;
      b_rdata2_d = b_rdata_c;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         a_rv2_q    <= 1'b0;
         b_rv2_q    <= 1'b0;
         a_rdata2_q <= '0;
         b_rdata2_q <= '0;
      end else begin
         a_rv2_q    <= a_rv2_d;
         b_rv2_q    <= b_rv2_d;
         a_rdata2_q <= a_rdata2_d;
         b_rdata2_q <= b_rdata2_d;
      end
   end

   assign a_rvalid_o = a_rv2_q;
   assign b_rvalid_o = b_rv2_q;
   assign a_rdata_o  = a_rdata2_q;
   assign b_rdata_o  = b_rdata2_q;
`else
   assign a_rvalid_o = a_rd_q;
   assign b_rvalid_o = b_rd_q;
   assign a_rdata_o  = a_rdata_c;
   assign b_rdata_o  = b_rdata_c;
`endif

endmodule
